// File: rtl/lcd_frame_if.sv
// lcd_frame_if: groups the frame request, string ROM and LCD bus signals of
// lcd_frame_tx.
//   begin_tx, index1, index2, cursor_pos : frame request from the menu controller
//   lcd_done                             : high while the transmitter is idle
//   rom_addr / rom_data                  : synchronous string ROM (1 clk latency)
//   lcd_rs, lcd_rw, lcd_en, lcd_data     : HD44780 8-bit parallel bus
// slave  : the lcd_frame_tx side
// master : the environment (controller, ROM, LCD)
interface lcd_frame_if;
  logic       begin_tx;
  logic [4:0] index1;
  logic [4:0] index2;
  logic [7:0] cursor_pos;
  logic       lcd_done;
  logic [8:0] rom_addr;
  logic [7:0] rom_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport slave (
    input  begin_tx, index1, index2, cursor_pos, rom_data,
    output lcd_done, rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport master (
    output begin_tx, index1, index2, cursor_pos, rom_data,
    input  lcd_done, rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/lcd_frame_tx.sv
// lcd_frame_tx: runs the HD44780 power-up/init sequence, then on request
// writes two 16-character strings fetched from a string ROM plus a selection
// marker at cursor_pos. Identical repeated requests are suppressed.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : lcd_frame_if.slave (request, ROM port, LCD bus, lcd_done)
//
// state  | meaning
// PWR    | power-up delay after reset
// IDLE   | lcd_done = 1, waiting for a new request
// FETCH0 | rom_addr driven for the next character
// FETCH1 | ROM data valid, captured into the byte register
// SETUP  | lcd_rs / lcd_data presented, lcd_en low
// EN     | lcd_en high
// WAIT   | lcd_en low, LCD busy time
module lcd_frame_tx #(
  parameter int unsigned POWERUP_CYCLES    = 1000000,
  parameter int unsigned EN_CYCLES         = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000,
  parameter logic [7:0]  MARKER            = 8'h3E
) (
  input  logic        clk,
  input  logic        reset,
  lcd_frame_if.slave  bus
);

  localparam logic [2:0] S_PWR    = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_FETCH0 = 3'd2;
  localparam logic [2:0] S_FETCH1 = 3'd3;
  localparam logic [2:0] S_SETUP  = 3'd4;
  localparam logic [2:0] S_EN     = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;

  localparam logic [19:0] PWR_LD = 20'(POWERUP_CYCLES);
  localparam logic [19:0] EN_LD  = 20'(EN_CYCLES);
  localparam logic [19:0] CMD_LD = 20'(CMD_WAIT_CYCLES);
  localparam logic [19:0] CLR_LD = 20'(CLEAR_WAIT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  step_q, step_d;
  logic        init_q, init_d;
  // request packing: {index1, index2, cursor_pos[6:0]}
  logic [16:0] lat_q, lat_d;
  logic [16:0] last_q, last_d;
  logic        last_valid_q, last_valid_d;
  logic        done_q, done_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;
  logic [8:0]  addr_q, addr_d;

  logic [16:0] req;
  logic [5:0]  nxt;
  logic [5:0]  col1;
  logic [5:0]  col2;

  assign req  = {bus.index1, bus.index2, bus.cursor_pos[6:0]};
  assign nxt  = step_q + 6'd1;
  assign col1 = nxt - 6'd1;
  assign col2 = nxt - 6'd18;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    init_d       = init_q;
    lat_d        = lat_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    rs_d         = rs_q;
    en_d         = en_q;
    data_d       = data_q;
    addr_d       = addr_q;

    case (state_q)
      S_PWR: begin
        if (cnt_q == 20'd1) begin
          init_d  = 1'b1;
          step_d  = 6'd0;
          rs_d    = 1'b0;
          data_d  = 8'h38;
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_IDLE: begin
        if (bus.begin_tx && (!last_valid_q || (req != last_q))) begin
          lat_d   = req;
          init_d  = 1'b0;
          step_d  = 6'd0;
          rs_d    = 1'b0;
          data_d  = 8'h80;
          state_d = S_SETUP;
        end
      end
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: begin
        data_d  = bus.rom_data;
        rs_d    = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = EN_LD;
        state_d = S_EN;
      end
      S_EN: begin
        if (cnt_q == 20'd1) begin
          en_d    = 1'b0;
          // only the clear command needs the long busy time
          cnt_d   = (!rs_q && (data_q == 8'h01)) ? CLR_LD : CMD_LD;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 20'd1) begin
          cnt_d = cnt_q - 20'd1;
        end else if (init_q) begin
          if (step_q == 6'd3) begin
            state_d = S_IDLE;
          end else begin
            step_d  = nxt;
            state_d = S_SETUP;
            case (nxt[1:0])
              2'd1:    data_d = 8'h0C;
              2'd2:    data_d = 8'h06;
              2'd3:    data_d = 8'h01;
              default: data_d = 8'h38;
            endcase
          end
        end else if (step_q == 6'd35) begin
          last_d       = lat_q;
          last_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          step_d = nxt;
          if (nxt == 6'd17) begin
            rs_d    = 1'b0;
            data_d  = 8'hC0;
            state_d = S_SETUP;
          end else if (nxt == 6'd34) begin
            rs_d    = 1'b0;
            data_d  = {1'b1, lat_q[6:0]};
            state_d = S_SETUP;
          end else if (nxt == 6'd35) begin
            rs_d    = 1'b1;
            data_d  = MARKER;
            state_d = S_SETUP;
          end else begin
            state_d = S_FETCH0;
            if (nxt <= 6'd16) addr_d = {lat_q[16:12], col1[3:0]};
            else              addr_d = {lat_q[11:7],  col2[3:0]};
          end
        end
      end
      default: begin
        state_d = S_PWR;
        cnt_d   = PWR_LD;
      end
    endcase

    done_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PWR;
      cnt_q        <= PWR_LD;
      step_q       <= 6'd0;
      init_q       <= 1'b0;
      lat_q        <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      addr_q       <= 9'h000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      init_q       <= init_d;
      lat_q        <= lat_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      done_q       <= done_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
    end
  end

  assign bus.lcd_done = done_q;
  assign bus.rom_addr = addr_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_data = data_q;

endmodule

// File: doc/lcd_frame_tx.md
Name: lcd_frame_tx

Overview:
- Display-side counterpart of the menu controller. Accepts that controller's begin_tx / index1 / index2 / cursor_pos request, fetches two 16-character strings from a synchronous string ROM, and writes them to an HD44780-class character LCD over its 8-bit parallel bus.
- Writes a selection marker at cursor_pos.
- Reports lcd_done while idle.
- Runs the LCD power-up/init sequence after reset.

Parameters:
- POWERUP_CYCLES, 1000000: wait after reset before the first init command (20 ms @ 50 MHz).
- EN_CYCLES, 25: lcd_en high width in clocks.
- CMD_WAIT_CYCLES, 2500: hold/wait after lcd_en falls, all bytes except clear.
- CLEAR_WAIT_CYCLES, 100000: wait after the clear command 0x01.
- MARKER, 8'h3E: marker character ('>').
- All cycle parameters are ≥1 and <2^20; one 20-bit down-counter serves all delays.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- begin_tx  in  1  frame request, level-sensitive
- index1  in  5  string ROM index for line 1
- index2  in  5  string ROM index for line 2
- cursor_pos  in  8  DDRAM address of marker (0x00 = line 1, 0x40 = line 2)
- lcd_done  out  1  high only in IDLE
- rom_addr  out  9  {index[4:0], column[3:0]}
- rom_data  in  8  ROM character; valid 1 clk after rom_addr
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0
- lcd_en  out  1  LCD enable strobe
- lcd_data  out  8  LCD bus

Behaviour:
- Reset, synchronous, wins over all activity including mid-frame:
  - All outputs go to 0; lcd_done = 0.
  - last_valid is cleared.
  - State = PWR with the counter loaded to POWERUP_CYCLES.
- PWR: count down, then INIT.
- INIT: send 0x38, 0x0C, 0x06, 0x01 in order, using the byte-write sequence with lcd_rs = 0. Then go to IDLE.
- Byte-write sequence, all registered:
  - SETUP: drive lcd_rs and lcd_data, 1 clk.
  - EN: lcd_en = 1 for EN_CYCLES.
  - WAIT: lcd_en = 0 for CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES for byte 0x01 with rs = 0.
  - lcd_rs and lcd_data stay stable from SETUP through the end of WAIT.
  - Cost = 1 + EN_CYCLES + wait.
- Character fetch precedes each string byte:
  - FETCH0 drives rom_addr.
  - FETCH1 captures rom_data into the byte register.
  - Adds 2 clks.
- IDLE:
  - lcd_done = 1.
  - If begin_tx = 1 and {index1, index2, cursor_pos} differs from the last_frame register, or last_valid = 0, then latch the inputs. lcd_done falls the next cycle and the frame starts.
  - If the request matches the last frame while valid, stay in IDLE with no bus activity. This prevents flicker while the controller holds begin_tx high.
- Frame, driven by a 6-bit step counter:
  - step 0: cmd 0x80
  - steps 1–16: line-1 chars, index1 columns 0–15
  - step 17: cmd 0xC0
  - steps 18–33: line-2 chars, index2 columns 0–15
  - step 34: cmd 0x80 | cursor_pos[6:0]
  - step 35: data MARKER, no fetch
  - Then last_frame ← latched inputs, last_valid ← 1, return to IDLE.
- Column 0 of every string is reserved blank; the marker overwrites it.
- Inputs changing mid-frame are ignored; only the latched copy is used. A changed request is served after the current frame ends.
- begin_tx during PWR/INIT is ignored; it is honoured on IDLE entry if still high.
- cursor_pos[7] is ignored.
- Frame length from acceptance cycle to lcd_done = 1:
  - 4 commands/marker × (1 + EN_CYCLES + CMD_WAIT_CYCLES)
  - plus 32 × (3 + EN_CYCLES + CMD_WAIT_CYCLES)
  - plus 1.

Test Plan:
- Test parameters: POWERUP = 10, EN = 2, CMD_WAIT = 4, CLEAR_WAIT = 8.
- Reset → outputs 0. After 10 clks: bytes 0x38, 0x0C, 0x06, 0x01 with rs = 0, each with lcd_en high 2 clks. The gap after 0x01 is 8 clks. Then lcd_done = 1.
- begin_tx = 1, index1 = 0, index2 = 1, cursor_pos = 0x40; ROM returns 0x40 + column → bus shows:
  - 0x80
  - 0x40..0x4F with rs = 1
  - 0xC0
  - 0x40..0x4F
  - 0xC0
  - 0x3E
  - lcd_done returns to 1 after 7·4 + 9·32 + 1 = 317 clks.
- Hold begin_tx = 1 with unchanged inputs for 500 clks after the frame → lcd_en stays 0 and lcd_done stays 1.
- Change cursor_pos to 0x00 while begin_tx is held → new frame; step-34 command is 0x80 and the marker is written there.
- Assert reset at step 20 of a frame → next cycle lcd_en = 0 and lcd_done = 0; init sequence repeats. Afterwards the same request retransmits because last_valid was cleared.
- Change index2 mid-frame → current frame uses the old index2; a second frame follows immediately with the new index2.
